imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: takes a byte stream (UART/debug bridge),

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 42 ++++
 rtl/imem_loader_byte_packer.sv | 56 +++++
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   - loader_state_e : loader FSM states (also driven out for debug)
//   - WORD_BYTES     : bytes per imem word
//   - LEN_W          : width of the frame's word-count field
//   - word_addr()    : byte address of word <idx> relative to a base address
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } loader_state_e;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;

  // Word index -> byte address. The index is at most 16 bits wide, so
  // {idx, 2'b00} never overflows the 32-bit address.
  function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                            input logic [LEN_W-1:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the loader's control, byte-stream and imem write-port signals.
//   Signal names keep the loader's point of view (_i = into the loader).
//
//   Stream handshake: a byte moves on a rising clock edge where both
//   rx_valid_i and rx_ready_o are high. The source holds rx_data_i stable
//   while rx_valid_i is high and no transfer has happened; the loader may
//   raise or drop rx_ready_o independently of rx_valid_i.
//
//   modport master : host side (drives start / stream, observes status)
//   modport slave  : loader side
//   state_o        : loader FSM state, for debug and checkers
// -----------------------------------------------------------------------------
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic          start_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          imem_we_o;
  logic [31:0]   imem_waddr_o;
  logic [31:0]   imem_wdata_o;
  logic          cpu_hold_o;
  logic          done_o;
  logic          error_o;
  loader_state_e state_o;

  modport master (
    output start_i, rx_data_i, rx_valid_i,
    input  rx_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o,
           cpu_hold_o, done_o, error_o, state_o
  );

  modport slave (
    input  start_i, rx_data_i, rx_valid_i,
    output rx_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o,
           cpu_hold_o, done_o, error_o, state_o
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
//   Assembles bytes little-endian into a 32-bit word: byte k of a word lands
//   in bits [8k+7:8k].
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     i_clr        : restart assembly at byte 0
//     i_push       : accept i_byte this cycle
//     i_byte       : incoming byte
//     o_word       : word as it stands after the current push (includes i_byte
//                    when i_push is high), so a completed word is usable in the
//                    same cycle as its last byte
//     o_full       : this push delivers the last byte of a word
// -----------------------------------------------------------------------------
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [31:0] w_word;

  always_comb begin
    w_word = r_word;
    if (i_push) begin
      case (r_idx)
        2'd0:    w_word[7:0]   = i_byte;
        2'd1:    w_word[15:8]  = i_byte;
        2'd2:    w_word[23:16] = i_byte;
        default: w_word[31:24] = i_byte;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_push) begin
      r_word <= w_word;
      r_idx  <= r_idx + 2'd1;  // wraps to 0 after the last byte of a word
    end
  end

  assign o_word = w_word;
  assign o_full = i_push && (r_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a load frame over a byte stream and writes it into the
//   instruction memory word by word, holding the CPU in reset meanwhile.
//   Frame: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes,
//   little-endian per word. Optional trailing checksum byte.
//
//   Parameters:
//     DEPTH_WORDS : imem depth in words; frames with N > DEPTH_WORDS are rejected
//     BASE_ADDR   : byte address of the first word written (word aligned)
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     bus (slave)  : start_i, rx_data_i/rx_valid_i/rx_ready_o stream,
//                    imem_we_o/imem_waddr_o/imem_wdata_o write port,
//                    cpu_hold_o, done_o, error_o status, state_o debug
//
//   Configuration macro IMEM_LOADER_CHECKSUM_EN: when defined, one extra byte
//   follows the data and must equal the 8-bit wrapping sum of all data bytes;
//   a mismatch ends in ERROR (words are already written by then).
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_loader_if.slave  bus
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  loader_state_e    r_state;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_idx;
  logic             r_rx_ready;
  logic             r_we;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;
  logic             r_hold;
  logic             r_done;
  logic             r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_xfer;
  logic             w_start;
  logic             w_push;
  logic [31:0]      w_word;
  logic             w_full;
  logic [LEN_W-1:0] w_len_n;
  logic [LEN_W-1:0] w_idx_next;

  assign w_xfer     = bus.rx_valid_i && r_rx_ready;
  // start_i only counts in the resting states; mid-load it is ignored.
  assign w_start    = bus.start_i &&
                      ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_push     = w_xfer && (r_state == DATA);
  assign w_len_n    = {bus.rx_data_i, r_len_lo};
  assign w_idx_next = r_word_idx + 16'd1;

  imem_loader_byte_packer u_packer (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_clr  (w_start),
    .i_push (w_push),
    .i_byte (bus.rx_data_i),
    .o_word (w_word),
    .o_full (w_full)
  );

  // All outputs are registered and updated together with the state, so each
  // output reflects the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_len_lo   <= 8'd0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= 32'd0;
      r_wdata    <= 32'd0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;  // write strobe lasts exactly one cycle
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_start) begin
            r_state    <= LEN_LO;
            r_rx_ready <= 1'b1;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
          end
        end

        LEN_LO: begin
          if (w_xfer) begin
            r_len_lo <= bus.rx_data_i;
            r_state  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (w_xfer) begin
            r_len <= w_len_n;
            if (w_len_n == '0) begin
              r_state    <= DONE;
              r_rx_ready <= 1'b0;
              r_hold     <= 1'b0;
              r_done     <= 1'b1;
            end else if (32'(w_len_n) > DEPTH_L) begin
              r_state    <= ERROR;
              r_rx_ready <= 1'b0;
              r_hold     <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end

        DATA: begin
          if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum + bus.rx_data_i;
`endif
            // Last byte of the word: launch the write in the very next cycle.
            if (w_full) begin
              r_state    <= WRITE;
              r_rx_ready <= 1'b0;
              r_we       <= 1'b1;
              r_waddr    <= word_addr(BASE_ADDR, r_word_idx);
              r_wdata    <= w_word;
            end
          end
        end

        WRITE: begin
          r_word_idx <= w_idx_next;
          r_rx_ready <= 1'b1;
          if (w_idx_next == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= CSUM;
`else
            r_state    <= DONE;
            r_rx_ready <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state <= DATA;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (w_xfer) begin
            r_rx_ready <= 1'b0;
            r_hold     <= 1'b0;
            if (bus.rx_data_i == r_csum) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          r_state    <= IDLE;
          r_rx_ready <= 1'b0;
          r_hold     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready_o   = r_rx_ready;
  assign bus.imem_we_o    = r_we;
  assign bus.imem_waddr_o = r_waddr;
  assign bus.imem_wdata_o = r_wdata;
  assign bus.cpu_hold_o   = r_hold;
  assign bus.done_o       = r_done;
  assign bus.error_o      = r_error;
  assign bus.state_o      = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed and randomized loads against imem_loader. The reference model
//   holds the image as a list of words; expected writes are (BASE + 4*i,
//   word i) and the stream bytes are derived from the words little-endian.
//   Honours IMEM_LOADER_CHECKSUM_EN (appends the checksum byte).
// -----------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [63:0] exp_q[$];   // expected {addr, data} writes
  logic [63:0] wr_q[$];    // observed {addr, data} writes
  logic [31:0] words[$];   // image for the current load

  // Write monitor: samples away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we_o === 1'b1) wr_q.push_back({bus.imem_waddr_o, bus.imem_wdata_o});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Presents one byte and returns #1 after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got = 1'b0;
    if (gaps) begin
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rx_ready_o === 1'b1) begin
        @(posedge clk); #1;
        got = 1'b1;
        break;
      end
    end
    bus.rx_valid_i = 1'b0;
    if (!got) check("rx_ready_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_end();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.error_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("end_timeout", 64'(seen), 64'd1);
  endtask

  // Full load of words[]; checks write latency, the write list and final status.
  task automatic run_load(input string tag, input bit gaps, input int csum_delta,
                          input bit exp_err);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    int         n   = words.size();
    wr_q.delete();
    exp_q.delete();
    pulse_start();
    check({tag, "_hold_on"}, 64'(bus.cpu_hold_o), 64'd1);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({BASE + 32'(i) * 32'd4, words[i]});
      for (int k = 0; k < 4; k++) begin
        b   = 8'(words[i] >> (8 * k));
        sum = sum + b;
        send_byte(b, gaps);
      end
      // Last byte accepted at the previous edge -> strobe high this cycle.
      check({tag, "_we_latency"}, 64'(bus.imem_we_o), 64'd1);
      check({tag, "_ready_in_write"}, 64'(bus.rx_ready_o), 64'd0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sum + 8'(csum_delta), gaps);
`else
    if (csum_delta != 0) $display("note: no checksum byte in this build");
`endif
    wait_end();
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_q.size() > 0)
      check({tag, "_write"}, wr_q.pop_front(), exp_q.pop_front());
    check({tag, "_done"},  64'(bus.done_o),     64'(!exp_err));
    check({tag, "_error"}, 64'(bus.error_o),    64'(exp_err));
    check({tag, "_hold"},  64'(bus.cpu_hold_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.rx_ready_o), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.rx_ready_o),   64'd0);
    check({tag, "_we"},    64'(bus.imem_we_o),    64'd0);
    check({tag, "_waddr"}, 64'(bus.imem_waddr_o), 64'd0);
    check({tag, "_wdata"}, 64'(bus.imem_wdata_o), 64'd0);
    check({tag, "_hold"},  64'(bus.cpu_hold_o),   64'd0);
    check({tag, "_done"},  64'(bus.done_o),       64'd0);
    check({tag, "_error"}, 64'(bus.error_o),      64'd0);
    check({tag, "_state"}, 64'(bus.state_o),      64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nw;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.rx_data_i  = 8'd0;
    bus.rx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // 1: two-word image from the example frame.
    words = '{32'h0000_0013, 32'h0010_0093};
    run_load("basic", 1'b0, 0, 1'b0);
    check("basic_waddr_hold", 64'(bus.imem_waddr_o), 64'h4);
    check("basic_wdata_hold", 64'(bus.imem_wdata_o), 64'h0010_0093);

    // 2: zero length -> done right after LEN_HI, no writes.
    wr_q.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("len0_done", 64'(bus.done_o), 64'd1);
    check("len0_hold", 64'(bus.cpu_hold_o), 64'd0);
    repeat (3) @(negedge clk);
    check("len0_nwrites", 64'(wr_q.size()), 64'd0);

    // 3: length 2049 -> rejected; stream ignored afterwards.
    wr_q.delete();
    pulse_start();
    check("len2049_done_cleared", 64'(bus.done_o), 64'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h08, 1'b0);
    check("len2049_error", 64'(bus.error_o), 64'd1);
    check("len2049_ready", 64'(bus.rx_ready_o), 64'd0);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'hA5;
    repeat (6) @(negedge clk);
    check("len2049_ready_held", 64'(bus.rx_ready_o), 64'd0);
    bus.rx_valid_i = 1'b0;
    check("len2049_nwrites", 64'(wr_q.size()), 64'd0);

    // Boundary: length exactly DEPTH is accepted (enters data phase).
    pulse_start();
    check("len2048_error_cleared", 64'(bus.error_o), 64'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b0);
    @(negedge clk);
    check("len2048_error", 64'(bus.error_o), 64'd0);
    check("len2048_ready", 64'(bus.rx_ready_o), 64'd1);
    check("len2048_hold",  64'(bus.cpu_hold_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // 4: 16 random words with random valid gaps.
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back($urandom);
    run_load("rand16", 1'b1, 0, 1'b0);

    // 5: reset after 6 data bytes, then a clean reload.
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    wr_q.delete();
    pulse_start();
    send_byte(8'd4, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int j = 0; j < 6; j++) send_byte(8'(words[j / 4] >> (8 * (j % 4))), 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    check("midreset_nwrites", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) check("midreset_write0", wr_q[0], {BASE, words[0]});
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    run_load("reload", 1'b1, 0, 1'b0);

    // Extra random loads of varied size and pacing.
    for (int t = 0; t < 4; t++) begin
      words.delete();
      nw = $urandom_range(1, 8);
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      run_load("rand_mix", 1'($urandom_range(0, 1)), 0, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum match / mismatch (sum of 04 03 02 01 = 0x0A).
    words = '{32'h0102_0304};
    run_load("csum_ok", 1'b0, 0, 1'b0);
    run_load("csum_bad", 1'b0, 1, 1'b1);
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    run_load("csum_rand_bad", 1'b1, $urandom_range(1, 255), 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
